// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/redirect controller.
package pipeline_ctrl_pkg;

    localparam int CNT_W  = 16;
    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEMWAIT  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // A load in EX whose non-zero destination feeds either source of the
    // instruction in ID must hold ID for one cycle.
    function automatic logic load_use_hazard(
        input logic             mem_read,
        input logic [REG_W-1:0] rd_addr,
        input logic [REG_W-1:0] rs_addr,
        input logic [REG_W-1:0] rt_addr
    );
        return mem_read && (rd_addr != '0) &&
               ((rd_addr == rs_addr) || (rd_addr == rt_addr));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// There is no valid/ready handshake here: every control is a level that the
// controller computes combinationally each cycle from state plus the hazard
// inputs, and the datapath obeys it on the next posedge.
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    // hazard/branch information from the datapath
    logic              mem_stall;
    logic              id_ex_mem_read;
    logic [REG_W-1:0]  id_ex_rd_addr;
    logic [REG_W-1:0]  if_id_rs_addr;
    logic [REG_W-1:0]  if_id_rt_addr;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;

    // controls back to the datapath
    logic              pc_write;
    logic              pc_src;
    logic [ADDR_W-1:0] pc_target;
    logic              if_id_write;
    logic              if_id_flush;
    logic              if_id_stall;
    logic              id_ex_bubble;
    logic [1:0]        state;

    modport master (
        output mem_stall, id_ex_mem_read, id_ex_rd_addr, if_id_rs_addr,
               if_id_rt_addr, branch_taken, branch_target,
        input  pc_write, pc_src, pc_target, if_id_write, if_id_flush,
               if_id_stall, id_ex_bubble, state
    );

    modport slave (
        input  mem_stall, id_ex_mem_read, id_ex_rd_addr, if_id_rs_addr,
               if_id_rt_addr, branch_taken, branch_target,
        output pc_write, pc_src, pc_target, if_id_write, if_id_flush,
               if_id_stall, id_ex_bubble, state
    );

endinterface

// File: rtl/pipeline_ctrl_fsm.sv
// Hazard FSM: memory freeze, load-use bubble, and branch redirect, with a
// pending-redirect register that carries a branch across a memory stall.
module pipeline_ctrl_fsm
    import pipeline_ctrl_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    pipeline_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    logic              load_use;
    logic              pc_write_c, pc_src_c, if_id_write_c;
    logic              if_id_flush_c, if_id_stall_c, id_ex_bubble_c;
    logic [ADDR_W-1:0] pc_target_c;

    assign load_use = load_use_hazard(bus.id_ex_mem_read, bus.id_ex_rd_addr,
                                      bus.if_id_rs_addr, bus.if_id_rt_addr);

    // next state and same-cycle controls; priority is freeze, load-use, branch
    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        pend_tgt_d     = pend_tgt_q;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        pc_src_c       = 1'b0;
        pc_target_c    = '0;
        if_id_flush_c  = 1'b0;
        if_id_stall_c  = 1'b0;
        id_ex_bubble_c = 1'b0;

        if (rst_i) begin
            // everything quiet while reset is held
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            state_d       = ST_RUN;
            pend_d        = 1'b0;
            pend_tgt_d    = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.mem_stall) begin
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                        if_id_stall_c = 1'b1;
                        state_d       = ST_MEMWAIT;
                    end else if (load_use) begin
                        pc_write_c     = 1'b0;
                        if_id_write_c  = 1'b0;
                        id_ex_bubble_c = 1'b1;
                    end else if (bus.branch_taken) begin
                        pc_src_c      = 1'b1;
                        pc_target_c   = bus.branch_target;
                        if_id_flush_c = 1'b1;
                    end
                end

                ST_MEMWAIT: begin
                    // only the first taken branch seen while frozen is kept
                    if (bus.branch_taken && !pend_q) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = bus.branch_target;
                    end
                    if (bus.mem_stall) begin
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                        if_id_stall_c = 1'b1;
                    end else begin
                        if (load_use) begin
                            pc_write_c     = 1'b0;
                            if_id_write_c  = 1'b0;
                            id_ex_bubble_c = 1'b1;
                        end
                        state_d = pend_d ? ST_REDIRECT : ST_RUN;
                    end
                end

                ST_REDIRECT: begin
                    if (bus.mem_stall) begin
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                        if_id_stall_c = 1'b1;
                        state_d       = ST_MEMWAIT;
                    end else if (load_use) begin
                        // redirect stays pending until the bubble is done
                        pc_write_c     = 1'b0;
                        if_id_write_c  = 1'b0;
                        id_ex_bubble_c = 1'b1;
                    end else begin
                        pc_src_c      = 1'b1;
                        pc_target_c   = pend_tgt_q;
                        if_id_flush_c = 1'b1;
                        pend_d        = 1'b0;
                        state_d       = ST_RUN;
                    end
                end

                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // state and pending-redirect registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    assign bus.pc_write     = pc_write_c;
    assign bus.pc_src       = pc_src_c;
    assign bus.pc_target    = pc_target_c;
    assign bus.if_id_write  = if_id_write_c;
    assign bus.if_id_flush  = if_id_flush_c;
    assign bus.if_id_stall  = if_id_stall_c;
    assign bus.id_ex_bubble = id_ex_bubble_c;
    assign bus.state        = state_q;

endmodule

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear wins, otherwise step unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Top of the pipeline controller: flat port shell around the hazard FSM
// plus stall and flush cycle counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_stall_i,
    input  logic              ID_EX_MemRead_i,
    input  logic [REG_W-1:0]  ID_EX_RDaddr_i,
    input  logic [REG_W-1:0]  IF_ID_RSaddr_i,
    input  logic [REG_W-1:0]  IF_ID_RTaddr_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              PC_write_o,
    output logic              PC_src_o,
    output logic [ADDR_W-1:0] PC_target_o,
    output logic              IF_ID_write_o,
    output logic              IF_ID_flush_o,
    output logic              IF_ID_stall_o,
    output logic              ID_EX_bubble_o,
    output logic [1:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    pipeline_ctrl_if ctl ();

    assign ctl.mem_stall      = mem_stall_i;
    assign ctl.id_ex_mem_read = ID_EX_MemRead_i;
    assign ctl.id_ex_rd_addr  = ID_EX_RDaddr_i;
    assign ctl.if_id_rs_addr  = IF_ID_RSaddr_i;
    assign ctl.if_id_rt_addr  = IF_ID_RTaddr_i;
    assign ctl.branch_taken   = branch_taken_i;
    assign ctl.branch_target  = branch_target_i;

    pipeline_ctrl_fsm u_fsm (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (ctl.slave)
    );

    assign PC_write_o     = ctl.pc_write;
    assign PC_src_o       = ctl.pc_src;
    assign PC_target_o    = ctl.pc_target;
    assign IF_ID_write_o  = ctl.if_id_write;
    assign IF_ID_flush_o  = ctl.if_id_flush;
    assign IF_ID_stall_o  = ctl.if_id_stall;
    assign ID_EX_bubble_o = ctl.id_ex_bubble;
    assign state_o        = ctl.state;

    // counters are held at zero during reset even though PC_write_o is low
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (!ctl.pc_write && !rst_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (ctl.if_id_flush && !rst_i),
        .cnt_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: inputs change 1 ns after posedge,
// outputs are sampled at the following negedge.
module tb_pipeline_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    int          n_checks;
    int          n_errors;

    pipeline_ctrl_if bus ();

    pipeline_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .mem_stall_i     (bus.mem_stall),
        .ID_EX_MemRead_i (bus.id_ex_mem_read),
        .ID_EX_RDaddr_i  (bus.id_ex_rd_addr),
        .IF_ID_RSaddr_i  (bus.if_id_rs_addr),
        .IF_ID_RTaddr_i  (bus.if_id_rt_addr),
        .branch_taken_i  (bus.branch_taken),
        .branch_target_i (bus.branch_target),
        .PC_write_o      (bus.pc_write),
        .PC_src_o        (bus.pc_src),
        .PC_target_o     (bus.pc_target),
        .IF_ID_write_o   (bus.if_id_write),
        .IF_ID_flush_o   (bus.if_id_flush),
        .IF_ID_stall_o   (bus.if_id_stall),
        .ID_EX_bubble_o  (bus.id_ex_bubble),
        .state_o         (bus.state),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ms, input logic mr, input logic [4:0] rd,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic br, input logic [31:0] tgt);
        bus.mem_stall      = ms;
        bus.id_ex_mem_read = mr;
        bus.id_ex_rd_addr  = rd;
        bus.if_id_rs_addr  = rs;
        bus.if_id_rt_addr  = rt;
        bus.branch_taken   = br;
        bus.branch_target  = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();

        // reset held: all controls low
        @(negedge clk);
        check("rst_pc_write", bus.pc_write, 0);
        check("rst_if_id_write", bus.if_id_write, 0);
        check("rst_pc_src", bus.pc_src, 0);
        check("rst_if_id_stall", bus.if_id_stall, 0);
        next_cycle();
        @(negedge clk);
        check("rst_state", bus.state, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        next_cycle();

        // idle after reset: defaults
        rst = 1'b0;
        @(negedge clk);
        check("idle_pc_write", bus.pc_write, 1);
        check("idle_if_id_write", bus.if_id_write, 1);
        check("idle_flush", bus.if_id_flush, 0);
        check("idle_bubble", bus.id_ex_bubble, 0);
        check("idle_state", bus.state, 0);
        next_cycle();

        // load-use on rs
        drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        check("lu_pc_write", bus.pc_write, 0);
        check("lu_if_id_write", bus.if_id_write, 0);
        check("lu_bubble", bus.id_ex_bubble, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check("lu_after_pc_write", bus.pc_write, 1);
        check("lu_after_bubble", bus.id_ex_bubble, 0);
        check("lu_stall_cnt", stall_cnt, 1);
        next_cycle();

        // load to r0 is not a hazard
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        check("r0_pc_write", bus.pc_write, 1);
        check("r0_bubble", bus.id_ex_bubble, 0);
        next_cycle();

        // load-use on rt
        drive(1'b0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 32'h0);
        @(negedge clk);
        check("lu_rt_bubble", bus.id_ex_bubble, 1);
        next_cycle();

        // branch in RUN
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_0040);
        @(negedge clk);
        check("br_pc_src", bus.pc_src, 1);
        check("br_target", bus.pc_target, 32'h40);
        check("br_flush", bus.if_id_flush, 1);
        check("br_pc_write", bus.pc_write, 1);
        check("br_stall_cnt", stall_cnt, 2);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0000_0040);
        @(negedge clk);
        check("br_after_pc_src", bus.pc_src, 0);
        check("br_after_target", bus.pc_target, 0);
        check("br_flush_cnt", flush_cnt, 1);
        next_cycle();

        // load-use and branch together: bubble wins
        drive(1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 32'h0000_0099);
        @(negedge clk);
        check("sim_bubble", bus.id_ex_bubble, 1);
        check("sim_flush", bus.if_id_flush, 0);
        check("sim_pc_src", bus.pc_src, 0);
        check("sim_target", bus.pc_target, 0);
        next_cycle();

        // memory stall 4 cycles, branches in cycles 2 and 3
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        check("ms1_stall", bus.if_id_stall, 1);
        check("ms1_pc_write", bus.pc_write, 0);
        check("ms1_if_id_write", bus.if_id_write, 0);
        check("ms1_state", bus.state, 0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_0080);
        @(negedge clk);
        check("ms2_stall", bus.if_id_stall, 1);
        check("ms2_state", bus.state, 1);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_00C0);
        @(negedge clk);
        check("ms3_stall", bus.if_id_stall, 1);
        check("ms3_flush", bus.if_id_flush, 0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        check("ms4_stall", bus.if_id_stall, 1);
        check("ms4_pc_src", bus.pc_src, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("ms_exit_state", bus.state, 1);
        check("ms_exit_stall", bus.if_id_stall, 0);
        check("ms_exit_pc_write", bus.pc_write, 1);
        next_cycle();
        @(negedge clk);
        check("redir_state", bus.state, 2);
        check("redir_pc_src", bus.pc_src, 1);
        check("redir_target", bus.pc_target, 32'h80);
        check("redir_flush", bus.if_id_flush, 1);
        next_cycle();
        @(negedge clk);
        check("redir_done_state", bus.state, 0);
        check("redir_done_pc_src", bus.pc_src, 0);
        check("ms_stall_cnt", stall_cnt, 7);
        check("ms_flush_cnt", flush_cnt, 2);
        next_cycle();

        // pending redirect delayed by a load-use in REDIRECT
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_0100);
        next_cycle();
        idle();
        @(negedge clk);
        check("rl_exit_state", bus.state, 1);
        next_cycle();
        drive(1'b0, 1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 32'h0);
        @(negedge clk);
        check("rl_hold_state", bus.state, 2);
        check("rl_hold_bubble", bus.id_ex_bubble, 1);
        check("rl_hold_pc_src", bus.pc_src, 0);
        check("rl_hold_flush", bus.if_id_flush, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("rl_redir_state", bus.state, 2);
        check("rl_redir_pc_src", bus.pc_src, 1);
        check("rl_redir_target", bus.pc_target, 32'h100);
        next_cycle();
        @(negedge clk);
        check("rl_done_state", bus.state, 0);
        check("rl_stall_cnt", stall_cnt, 10);
        check("rl_flush_cnt", flush_cnt, 3);
        next_cycle();

        // reset in MEMWAIT with a pending redirect
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 32'h0000_0200);
        @(negedge clk);
        check("rm_state", bus.state, 1);
        next_cycle();
        rst = 1'b1;
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        check("rm_rst_pc_write", bus.pc_write, 0);
        check("rm_rst_stall", bus.if_id_stall, 0);
        check("rm_rst_pc_src", bus.pc_src, 0);
        next_cycle();
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("rm_state_after", bus.state, 0);
        check("rm_pc_src_after", bus.pc_src, 0);
        check("rm_flush_after", bus.if_id_flush, 0);
        check("rm_stall_cnt", stall_cnt, 0);
        check("rm_flush_cnt", flush_cnt, 0);
        next_cycle();
        @(negedge clk);
        check("rm_no_redirect_state", bus.state, 0);
        check("rm_no_redirect_pc_src", bus.pc_src, 0);
        next_cycle();

        // stall counter saturation
        drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        check("sat_stall_cnt", stall_cnt, 32'hFFFF);
        check("sat_state", bus.state, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check("sat_hold_cnt", stall_cnt, 32'hFFFF);
        check("sat_exit_pc_write", bus.pc_write, 1);
        next_cycle();
        @(negedge clk);
        check("sat_run_state", bus.state, 0);
        check("sat_final_cnt", stall_cnt, 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
